// File: rtl/pwm_btn_pkg.sv
// Shared types and defaults for the PWM button conditioner.
// Holds the FSM state encoding, default parameters and a width helper.
package pwm_btn_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD_UP = 3'd1,
    HOLD_DN = 3'd2,
    RPT_UP  = 3'd3,
    RPT_DN  = 3'd4,
    LOCK    = 3'd5
  } state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY    = 2048;
  localparam int DEF_REPEAT_PERIOD   = 512;

  // Counter width able to hold the value n itself.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/pwm_btn_debounce.sv
// Per-button 2-flop synchronizer plus saturating-count debouncer.
// Ports: clk, rst (sync, active-high), raw_i (async button), level_o (debounced level).
module pwm_btn_debounce
  import pwm_btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  // The count reaches CNT_MAX after DEBOUNCE_CYCLES differing samples;
  // the level flips on the following differing sample. A matching
  // sample at any point restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/pwm_btn_cond.sv
// Up/down button conditioner producing duty_inc/duty_dec pulses for a PWM.
// Ports: clk, rst, en, btn_up_raw, btn_dn_raw -> duty_inc, duty_dec, btn_conflict.
// Macro PWM_BTN_AUTOREPEAT_EN builds the hold-to-repeat states and counter.
module pwm_btn_cond
  import pwm_btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic btn_up_raw,
  input  logic btn_dn_raw,
  output logic duty_inc,
  output logic duty_dec,
  output logic btn_conflict
);

  logic   up_lvl;
  logic   dn_lvl;
  logic   up_prev_q;
  logic   dn_prev_q;
  logic   inc_q;
  logic   dec_q;
  logic   conf_q;
  state_e state_q;

  pwm_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_up (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (btn_up_raw),
    .level_o(up_lvl)
  );

  pwm_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_dn (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (btn_dn_raw),
    .level_o(dn_lvl)
  );

`ifdef PWM_BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = cnt_width(RMAX);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);
  logic [RW-1:0] rcnt_q;
`else
  logic unused_rpt;
  assign unused_rpt = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  logic both;
  logic up_rise;
  logic dn_rise;

  assign both    = up_lvl & dn_lvl;
  assign up_rise = up_lvl & ~up_prev_q;
  assign dn_rise = dn_lvl & ~dn_prev_q;

  // Edge history keeps tracking while disabled, so a button already
  // held when en rises never looks like a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      conf_q    <= 1'b0;
      up_prev_q <= 1'b0;
      dn_prev_q <= 1'b0;
`ifdef PWM_BTN_AUTOREPEAT_EN
      rcnt_q    <= '0;
`endif
    end else begin
      up_prev_q <= up_lvl;
      dn_prev_q <= dn_lvl;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      conf_q    <= 1'b0;
      if (!en) begin
        state_q <= IDLE;
`ifdef PWM_BTN_AUTOREPEAT_EN
        rcnt_q  <= '0;
`endif
      end else if (both) begin
        state_q <= LOCK;
        conf_q  <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
`ifdef PWM_BTN_AUTOREPEAT_EN
            rcnt_q <= '0;
`endif
            if (up_rise) begin
              inc_q   <= 1'b1;
              state_q <= HOLD_UP;
            end else if (dn_rise) begin
              dec_q   <= 1'b1;
              state_q <= HOLD_DN;
            end
          end
          HOLD_UP: begin
            if (!up_lvl) begin
              state_q <= IDLE;
            end
`ifdef PWM_BTN_AUTOREPEAT_EN
            else if (rcnt_q == DLY_LAST) begin
              inc_q   <= 1'b1;
              rcnt_q  <= '0;
              state_q <= RPT_UP;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
`endif
          end
          HOLD_DN: begin
            if (!dn_lvl) begin
              state_q <= IDLE;
            end
`ifdef PWM_BTN_AUTOREPEAT_EN
            else if (rcnt_q == DLY_LAST) begin
              dec_q   <= 1'b1;
              rcnt_q  <= '0;
              state_q <= RPT_DN;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
`endif
          end
`ifdef PWM_BTN_AUTOREPEAT_EN
          RPT_UP: begin
            if (!up_lvl) begin
              state_q <= IDLE;
            end else if (rcnt_q == PER_LAST) begin
              inc_q  <= 1'b1;
              rcnt_q <= '0;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end
          RPT_DN: begin
            if (!dn_lvl) begin
              state_q <= IDLE;
            end else if (rcnt_q == PER_LAST) begin
              dec_q  <= 1'b1;
              rcnt_q <= '0;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end
`endif
          LOCK: begin
            // Leave only once both buttons are back down.
            if (!up_lvl && !dn_lvl) begin
              state_q <= IDLE;
            end else begin
              conf_q <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign duty_inc     = inc_q;
  assign duty_dec     = dec_q;
  assign btn_conflict = conf_q;

endmodule

// File: tb/tb_pwm_btn_cond.sv
// Directed testbench for pwm_btn_cond (D=4, delay=20, period=8).
// Pulse times are counted in edges after the first sampling edge.
module tb_pwm_btn_cond;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic btn_up_raw;
  logic btn_dn_raw;
  logic duty_inc;
  logic duty_dec;
  logic btn_conflict;

  int checks = 0;
  int errors = 0;
  int t;
  int viol = 0;
  int inc_t[$];
  int dec_t[$];
  logic prev_inc = 1'b0;
  logic prev_dec = 1'b0;

  pwm_btn_cond #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .btn_up_raw  (btn_up_raw),
    .btn_dn_raw  (btn_dn_raw),
    .duty_inc    (duty_inc),
    .duty_dec    (duty_dec),
    .btn_conflict(btn_conflict)
  );

  always #5 clk = ~clk;

  task automatic clr();
    t = 0;
    inc_t.delete();
    dec_t.delete();
  endtask

  // Advance n edges, logging pulse times and pulse-rule violations.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      t++;
      if (duty_inc === 1'b1) inc_t.push_back(t);
      if (duty_dec === 1'b1) dec_t.push_back(t);
      if ((duty_inc && duty_dec) || (duty_inc && prev_inc) ||
          (duty_dec && prev_dec))
        viol++;
      prev_inc = duty_inc;
      prev_dec = duty_dec;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    btn_up_raw = 1'b1;
    btn_dn_raw = 1'b0;
    clr();
    step(10);
    checks++;
    if (duty_inc !== 1'b0) begin
      errors++;
      $display("FAIL rst_inc: got %b want 0", duty_inc);
    end
    checks++;
    if (duty_dec !== 1'b0) begin
      errors++;
      $display("FAIL rst_dec: got %b want 0", duty_dec);
    end
    checks++;
    if (btn_conflict !== 1'b0) begin
      errors++;
      $display("FAIL rst_conf: got %b want 0", btn_conflict);
    end
    checks++;
    if (inc_t.size() != 0) begin
      errors++;
      $display("FAIL rst_nopulse: got %0d pulses want 0", inc_t.size());
    end
    btn_up_raw = 1'b0;
    step(2);
    rst = 1'b0;
    step(4);
  endtask

  task automatic test_clean_press();
    clr();
    btn_up_raw = 1'b1;
    step(10);
    btn_up_raw = 1'b0;
    step(12);
    checks++;
    if (inc_t.size() != 1) begin
      errors++;
      $display("FAIL press_cnt: got %0d want 1", inc_t.size());
    end
    checks++;
    if (inc_t.size() < 1 || inc_t[0] != 8) begin
      errors++;
      $display("FAIL press_time: got %0d want 8",
               (inc_t.size() > 0) ? inc_t[0] : -1);
    end
    checks++;
    if (dec_t.size() != 0) begin
      errors++;
      $display("FAIL press_dec: got %0d want 0", dec_t.size());
    end
  endtask

  task automatic test_bounce();
    clr();
    for (int i = 0; i < 20; i++) begin
      btn_up_raw = ~btn_up_raw;
      step(2);
    end
    btn_up_raw = 1'b0;
    step(15);
    checks++;
    if (inc_t.size() + dec_t.size() != 0) begin
      errors++;
      $display("FAIL bounce: got %0d pulses want 0",
               inc_t.size() + dec_t.size());
    end
  endtask

  task automatic test_repeat();
    int exp_t[$];
`ifdef PWM_BTN_AUTOREPEAT_EN
    exp_t = '{8, 28, 36, 44, 52, 60};
`else
    exp_t = '{8};
`endif
    clr();
    btn_dn_raw = 1'b1;
    step(60);
    btn_dn_raw = 1'b0;
    step(12);
    checks++;
    if (dec_t.size() != exp_t.size()) begin
      errors++;
      $display("FAIL rpt_cnt: got %0d want %0d",
               dec_t.size(), exp_t.size());
    end
    for (int i = 0; i < exp_t.size(); i++) begin
      checks++;
      if (i >= dec_t.size() || dec_t[i] != exp_t[i]) begin
        errors++;
        $display("FAIL rpt_time[%0d]: got %0d want %0d", i,
                 (i < dec_t.size()) ? dec_t[i] : -1, exp_t[i]);
      end
    end
    checks++;
    if (inc_t.size() != 0) begin
      errors++;
      $display("FAIL rpt_inc: got %0d want 0", inc_t.size());
    end
  endtask

  task automatic test_conflict();
    clr();
    btn_up_raw = 1'b1;
    step(10);
    btn_dn_raw = 1'b1;
    step(12);
    checks++;
    if (btn_conflict !== 1'b1) begin
      errors++;
      $display("FAIL conf_set: got %b want 1", btn_conflict);
    end
    btn_dn_raw = 1'b0;
    step(12);
    checks++;
    if (btn_conflict !== 1'b1) begin
      errors++;
      $display("FAIL conf_hold: got %b want 1", btn_conflict);
    end
    btn_up_raw = 1'b0;
    step(12);
    checks++;
    if (btn_conflict !== 1'b0) begin
      errors++;
      $display("FAIL conf_clear: got %b want 0", btn_conflict);
    end
    checks++;
    if (inc_t.size() != 1 || inc_t[0] != 8 || dec_t.size() != 0) begin
      errors++;
      $display("FAIL conf_pulses: got inc=%0d dec=%0d want inc=1 dec=0",
               inc_t.size(), dec_t.size());
    end
    clr();
    btn_up_raw = 1'b1;
    step(10);
    btn_up_raw = 1'b0;
    step(12);
    checks++;
    if (inc_t.size() != 1 || inc_t[0] != 8) begin
      errors++;
      $display("FAIL conf_repress: got %0d pulses want 1 at 8",
               inc_t.size());
    end
  endtask

  task automatic test_enable();
    clr();
    en = 1'b0;
    btn_up_raw = 1'b1;
    step(10);
    en = 1'b1;
    step(10);
    checks++;
    if (inc_t.size() != 0) begin
      errors++;
      $display("FAIL en_held: got %0d pulses want 0", inc_t.size());
    end
    btn_up_raw = 1'b0;
    step(12);
    clr();
    btn_up_raw = 1'b1;
    step(10);
    btn_up_raw = 1'b0;
    step(12);
    checks++;
    if (inc_t.size() != 1 || inc_t[0] != 8) begin
      errors++;
      $display("FAIL en_repress: got %0d pulses want 1 at 8",
               inc_t.size());
    end
  endtask

  task automatic test_rst_mid();
    clr();
    btn_dn_raw = 1'b1;
    step(40);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++;
      if (duty_inc || duty_dec || btn_conflict) begin
        errors++;
        $display("FAIL rstmid_out[%0d]: got %b%b%b want 000", i,
                 duty_inc, duty_dec, btn_conflict);
      end
    end
    rst = 1'b0;
    clr();
    step(12);
    checks++;
    if (dec_t.size() != 1 || dec_t[0] != 8) begin
      errors++;
      $display("FAIL rstmid_pulse: got %0d pulses first %0d want 1 at 8",
               dec_t.size(), (dec_t.size() > 0) ? dec_t[0] : -1);
    end
    btn_dn_raw = 1'b0;
    step(12);
  endtask

  task automatic test_back_to_back();
    clr();
    btn_up_raw = 1'b1;
    step(10);
    btn_up_raw = 1'b0;
    step(12);
    btn_dn_raw = 1'b1;
    step(10);
    btn_dn_raw = 1'b0;
    step(12);
    checks++;
    if (inc_t.size() != 1 || inc_t[0] != 8) begin
      errors++;
      $display("FAIL b2b_inc: got %0d pulses want 1 at 8", inc_t.size());
    end
    checks++;
    if (dec_t.size() != 1 || dec_t[0] != 30) begin
      errors++;
      $display("FAIL b2b_dec: got %0d pulses first %0d want 1 at 30",
               dec_t.size(), (dec_t.size() > 0) ? dec_t[0] : -1);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_conflict();
    test_enable();
    test_rst_mid();
    test_back_to_back();
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL pulse_rules: got %0d violations want 0", viol);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
